// File: rtl/obstacle_pool_control.sv
// Pool of NUM_OBS obstacle slots: spawn at the right edge, arc up and down, scroll left.
// Optional OBS_SPEED_RAMP_EN: speed steps up every PASSES_PER_STEP exits and drops back on a hit.
module obstacle_pool_control #(
    parameter int unsigned NUM_OBS         = 3,
    parameter int unsigned OBS_W           = 30,
    parameter int unsigned OBS_H           = 30,
    parameter int unsigned SPEED_INIT      = 5,
    parameter int unsigned SPEED_MAX       = 12,
    parameter int unsigned WAIT_CYCLES     = 12,
    parameter int unsigned PASSES_PER_STEP = 4,
    parameter int unsigned Y_BASELINE      = 315,
    parameter int unsigned Y_INIT_OFFSET   = 50,
    parameter int unsigned Y_STEP          = 3,
    parameter int unsigned Y_AMP_MAX       = 200
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    game_en_i,
    input  logic [NUM_OBS-1:0]      collision_vec_i,
    input  logic [9:0]              y_amplitude_in_i,
    output logic [10*NUM_OBS-1:0]   obs_x_flat_o,
    output logic [10*NUM_OBS-1:0]   obs_y_flat_o,
    output logic [NUM_OBS-1:0]      obs_active_o,
    output logic [9:0]              obstacle_width_o,
    output logic [9:0]              obstacle_height_o,
    output logic [3:0]              speed_o,
    output logic                    pass_pulse_o,
    output logic                    hit_pulse_o
);

    typedef enum logic [1:0] {StIdle, StRise, StFall, StGround} state_e;

    localparam logic [9:0]      XStart    = 10'd640;
    localparam logic [9:0]      YGround   = 10'(Y_BASELINE - OBS_H);
    localparam logic [9:0]      YStep     = 10'(Y_STEP);
    localparam logic [10:0]     AmpMax    = 11'(Y_AMP_MAX);
    localparam logic [3:0]      SpeedInit = 4'(SPEED_INIT);
    localparam int unsigned     CntW      = $clog2(WAIT_CYCLES + 2);
    localparam logic [CntW-1:0] CntMax    = CntW'(WAIT_CYCLES);

    state_e          state_q [NUM_OBS];
    state_e          state_d [NUM_OBS];
    logic [9:0]      x_q [NUM_OBS];
    logic [9:0]      x_d [NUM_OBS];
    logic [9:0]      off_q [NUM_OBS];
    logic [9:0]      off_d [NUM_OBS];
    logic [9:0]      amp_q [NUM_OBS];
    logic [9:0]      amp_d [NUM_OBS];
    logic [9:0]      y_q [NUM_OBS];
    logic [9:0]      y_d [NUM_OBS];
    logic [CntW-1:0] spawn_cnt_q, spawn_cnt_d;
    logic            pass_q, pass_d, hit_q, hit_d;
    logic            any_exit, any_hit, spawned;
    logic [10:0]     amp_sum;
    logic [9:0]      amp_new;
    logic [3:0]      speed;

    // 11-bit sum so a large random amplitude saturates instead of wrapping.
    assign amp_sum = 11'(Y_INIT_OFFSET) + {1'b0, y_amplitude_in_i};
    assign amp_new = (amp_sum > AmpMax) ? AmpMax[9:0] : amp_sum[9:0];

    always_comb begin
        spawn_cnt_d = spawn_cnt_q;
        any_exit    = 1'b0;
        any_hit     = 1'b0;
        spawned     = 1'b0;
        for (int i = 0; i < int'(NUM_OBS); i++) begin
            state_d[i] = state_q[i];
            x_d[i]     = x_q[i];
            off_d[i]   = off_q[i];
            amp_d[i]   = amp_q[i];
            if (game_en_i) begin
                if (state_q[i] == StIdle) begin
                    if (!spawned && spawn_cnt_q == CntMax) begin
                        spawned    = 1'b1;
                        state_d[i] = StRise;
                        x_d[i]     = XStart;
                        off_d[i]   = '0;
                        amp_d[i]   = amp_new;
                    end
                end else if (collision_vec_i[i]) begin
                    any_hit    = 1'b1;
                    state_d[i] = StIdle;
                    x_d[i]     = XStart;
                    off_d[i]   = '0;
                end else if (x_q[i] <= {6'd0, speed}) begin
                    any_exit   = 1'b1;
                    state_d[i] = StIdle;
                    x_d[i]     = XStart;
                    off_d[i]   = '0;
                end else begin
                    x_d[i] = x_q[i] - {6'd0, speed};
                    case (state_q[i])
                        StRise: begin
                            if (off_q[i] < amp_q[i]) off_d[i] = off_q[i] + YStep;
                            else                     state_d[i] = StFall;
                        end
                        StFall: begin
                            if (off_q[i] <= YStep) begin
                                off_d[i]   = '0;
                                state_d[i] = StGround;
                            end else begin
                                off_d[i] = off_q[i] - YStep;
                            end
                        end
                        default: off_d[i] = '0;
                    endcase
                end
            end
            y_d[i] = YGround - off_d[i];
        end
        if (game_en_i) begin
            if (spawned)                   spawn_cnt_d = '0;
            else if (spawn_cnt_q != CntMax) spawn_cnt_d = spawn_cnt_q + CntW'(1);
        end
        // Pulses are strobes: they fall on the first clock without a tick.
        pass_d = game_en_i & any_exit;
        hit_d  = game_en_i & any_hit;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NUM_OBS); i++) begin
                state_q[i] <= StIdle;
                x_q[i]     <= XStart;
                off_q[i]   <= '0;
                amp_q[i]   <= '0;
                y_q[i]     <= YGround;
            end
            spawn_cnt_q <= '0;
            pass_q      <= 1'b0;
            hit_q       <= 1'b0;
        end else begin
            for (int i = 0; i < int'(NUM_OBS); i++) begin
                state_q[i] <= state_d[i];
                x_q[i]     <= x_d[i];
                off_q[i]   <= off_d[i];
                amp_q[i]   <= amp_d[i];
                y_q[i]     <= y_d[i];
            end
            spawn_cnt_q <= spawn_cnt_d;
            pass_q      <= pass_d;
            hit_q       <= hit_d;
        end
    end

`ifdef OBS_SPEED_RAMP_EN
    localparam int unsigned      PassW    = $clog2(PASSES_PER_STEP + 1);
    localparam logic [PassW-1:0] PassLast = PassW'(PASSES_PER_STEP - 1);
    localparam logic [3:0]       SpeedMax = 4'(SPEED_MAX);

    logic [PassW-1:0] pass_cnt_q, pass_cnt_d;
    logic [3:0]       speed_q, speed_d;

    always_comb begin
        pass_cnt_d = pass_cnt_q;
        speed_d    = speed_q;
        if (any_hit) begin
            pass_cnt_d = '0;
            speed_d    = SpeedInit;
        end else if (any_exit) begin
            if (pass_cnt_q == PassLast) begin
                pass_cnt_d = '0;
                if (speed_q < SpeedMax) speed_d = speed_q + 4'd1;
            end else begin
                pass_cnt_d = pass_cnt_q + PassW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pass_cnt_q <= '0;
            speed_q    <= SpeedInit;
        end else begin
            pass_cnt_q <= pass_cnt_d;
            speed_q    <= speed_d;
        end
    end

    assign speed = speed_q;
`else
    assign speed = SpeedInit;
`endif

    always_comb begin
        for (int i = 0; i < int'(NUM_OBS); i++) begin
            obs_x_flat_o[10*i +: 10] = x_q[i];
            obs_y_flat_o[10*i +: 10] = y_q[i];
            obs_active_o[i]          = (state_q[i] != StIdle);
        end
    end

    assign obstacle_width_o  = 10'(OBS_W);
    assign obstacle_height_o = 10'(OBS_H);
    assign speed_o           = speed;
    assign pass_pulse_o      = pass_q;
    assign hit_pulse_o       = hit_q;

endmodule

// File: tb/tb_obstacle_pool_control.sv
// Directed bench for obstacle_pool_control with default parameters (3 slots).
// Speed-ramp checks are compiled in when OBS_SPEED_RAMP_EN is defined.
module tb_obstacle_pool_control;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        game_en = 1'b0;
    logic [2:0]  coll = 3'b000;
    logic [9:0]  amp_in = 10'd20;
    logic [29:0] obs_x, obs_y;
    logic [2:0]  active;
    logic [9:0]  wdt, hgt;
    logic [3:0]  speed;
    logic        pass, hit;

    int total = 0;
    int bad = 0;
    int tick_no = 0;
    logic last_pass, last_hit;

    obstacle_pool_control dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .game_en_i         (game_en),
        .collision_vec_i   (coll),
        .y_amplitude_in_i  (amp_in),
        .obs_x_flat_o      (obs_x),
        .obs_y_flat_o      (obs_y),
        .obs_active_o      (active),
        .obstacle_width_o  (wdt),
        .obstacle_height_o (hgt),
        .speed_o           (speed),
        .pass_pulse_o      (pass),
        .hit_pulse_o       (hit)
    );

    always #10 clk = ~clk;

    function automatic int xs(input int i);
        return int'(obs_x[10*i +: 10]);
    endfunction

    function automatic int ys(input int i);
        return int'(obs_y[10*i +: 10]);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One game tick: game_en high for one clk, then one quiet clk.
    task automatic tick();
        game_en = 1'b1;
        @(negedge clk);
        game_en = 1'b0;
        last_pass = pass;
        last_hit  = hit;
        tick_no++;
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int i = 0; i < 3; i++) begin
            check({tag, " x"}, xs(i), 640);
            check({tag, " y"}, ys(i), 285);
        end
        check({tag, " active"}, int'(active), 0);
        check({tag, " speed"}, int'(speed), 5);
        check({tag, " pass"}, int'(pass), 0);
        check({tag, " hit"}, int'(hit), 0);
    endtask

    typedef struct {
        int         t;
        logic [2:0] c;
        int         x0;
        int         y0;
        int         x1;
        logic [2:0] act;
        logic       p;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int miny;
        // Slot0 spawns tick 13, slot1 tick 26, slot2 tick 39; amp 70 with amp_in=20.
        vecs[0] = '{12,  3'b000, 640, 285, 640, 3'b000, 1'b0};
        vecs[1] = '{13,  3'b000, 640, 285, 640, 3'b001, 1'b0};
        vecs[2] = '{18,  3'b110, 615, 270, 640, 3'b001, 1'b0};
        vecs[3] = '{37,  3'b000, 520, 213, 585, 3'b011, 1'b0};
        vecs[4] = '{38,  3'b000, 515, 213, 580, 3'b011, 1'b0};
        vecs[5] = '{39,  3'b000, 510, 216, 575, 3'b111, 1'b0};
        vecs[6] = '{62,  3'b000, 395, 285, 460, 3'b111, 1'b0};
        vecs[7] = '{140, 3'b000, 5,   285, 70,  3'b111, 1'b0};
        vecs[8] = '{141, 3'b000, 640, 285, 65,  3'b110, 1'b1};
        vecs[9] = '{142, 3'b000, 640, 285, 60,  3'b111, 1'b0};

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        check("width", int'(wdt), 30);
        check("height", int'(hgt), 30);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[k]) begin
            while (tick_no < vecs[k].t) begin
                coll = vecs[k].c;
                tick();
            end
            coll = 3'b000;
            check($sformatf("t%0d x0", vecs[k].t), xs(0), vecs[k].x0);
            check($sformatf("t%0d y0", vecs[k].t), ys(0), vecs[k].y0);
            check($sformatf("t%0d x1", vecs[k].t), xs(1), vecs[k].x1);
            check($sformatf("t%0d active", vecs[k].t), int'(active), int'(vecs[k].act));
            check($sformatf("t%0d pass", vecs[k].t), int'(last_pass), int'(vecs[k].p));
            check($sformatf("t%0d hit", vecs[k].t), int'(last_hit), 0);
            check($sformatf("t%0d speed", vecs[k].t), int'(speed), 5);
        end

        // Collision on the same tick slot1 would have exited: hit only, no pass.
        while (tick_no < 153) tick();
        check("pre-exit x1", xs(1), 5);
        coll = 3'b010;
        tick();
        coll = 3'b000;
        check("coll active", int'(active), 3'b101);
        check("coll x1", xs(1), 640);
        check("coll hit", int'(last_hit), 1);
        check("coll pass", int'(last_pass), 0);
        check("hit falls", int'(hit), 0);
        check("coll x0", xs(0), 580);
        check("coll x2", xs(2), 65);

        // Freed slot1 respawns the following tick with a saturated amplitude.
        amp_in = 10'd900;
        tick();
        check("respawn active", int'(active), 3'b111);
        check("respawn x1", xs(1), 640);
        miny = 1023;
        repeat (80) begin
            tick();
            if (ys(1) < miny) miny = ys(1);
        end
        check("peak y1", miny, 84);
        check("fall y1", ys(1), 120);

        // Asynchronous reset mid-flight (slot1 is falling).
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1 check_reset_outputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        amp_in = 10'd20;
        tick_no = 0;
        repeat (12) tick();
        check("post-reset t12 active", int'(active), 0);
        tick();
        check("post-reset t13 active", int'(active), 3'b001);
        check("post-reset t13 x0", xs(0), 640);

`ifdef OBS_SPEED_RAMP_EN
        begin
            int npass = 0;
            int budget = 4000;
            int exp_spd;
            while (npass < 36 && budget > 0) begin
                tick();
                budget--;
                if (last_pass) begin
                    npass++;
                    exp_spd = 5 + npass / 4;
                    if (exp_spd > 12) exp_spd = 12;
                    check($sformatf("ramp pass%0d speed", npass), int'(speed), exp_spd);
                end
            end
            check("ramp passes seen", npass, 36);
            coll = 3'b111;
            tick();
            coll = 3'b000;
            check("ramp hit", int'(last_hit), 1);
            check("ramp hit speed", int'(speed), 5);
        end
`else
        repeat (20) tick();
        check("fixed speed", int'(speed), 5);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/obstacle_pool_control.md
OBSTACLE_POOL_CONTROL -- requirements
Module: obstacle_pool_control

Interface
REQ-001 SHALL have parameter NUM_OBS, default 3: number of independent obstacle slots, legal range 1..8.
REQ-002 SHALL have parameter OBS_W, default 30: obstacle width, pixels.
REQ-003 SHALL have parameter OBS_H, default 30: obstacle height, pixels.
REQ-004 SHALL have parameter SPEED_INIT, default 5: initial horizontal step per game_en tick.
REQ-005 SHALL have parameter SPEED_MAX, default 12: speed ceiling.
REQ-006 SHALL have parameter WAIT_CYCLES, default 12: game_en ticks between spawns.
REQ-007 SHALL have parameter PASSES_PER_STEP, default 4: passes per speed increment.
REQ-008 SHALL have parameters Y_BASELINE default 315, Y_INIT_OFFSET default 50, Y_STEP default 3, Y_AMP_MAX default 200.
REQ-009 SHALL have port clk, input, 1: 50 MHz system clock.
REQ-010 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-011 SHALL have port game_en, input, 1: one-clk slow tick enable.
REQ-012 SHALL have port collision_vec, input, NUM_OBS: per-slot collision from the detector.
REQ-013 SHALL have port y_amplitude_in, input, 10: random arc amplitude.
REQ-014 SHALL have port obs_x_flat, output, 10*NUM_OBS: slot i x at bits [10i+9:10i].
REQ-015 SHALL have port obs_y_flat, output, 10*NUM_OBS: slot i top-edge y, same packing.
REQ-016 SHALL have port obs_active, output, NUM_OBS: slot visible/collidable.
REQ-017 SHALL have ports obstacle_width and obstacle_height, output, 10 each: constants OBS_W and OBS_H.
REQ-018 SHALL have port speed, output, 4: current horizontal step.
REQ-019 SHALL have ports pass_pulse and hit_pulse, output, 1 each: event strobes.

Function
REQ-020 All state SHALL update only on clk edges with game_en=1, except that pulses deassert on the next clk.
REQ-021 Each slot SHALL run an FSM with states IDLE, RISE, FALL and GROUND; obs_active[i]=1 in every state except IDLE.
REQ-022 The spawn counter SHALL increment per tick up to WAIT_CYCLES and hold there.
REQ-023 On a tick with counter==WAIT_CYCLES and at least one IDLE slot, the lowest-index IDLE slot SHALL spawn: x=640, offset=0, state RISE, and the counter SHALL clear to 0.
REQ-024 At spawn, amp SHALL latch min(Y_INIT_OFFSET+y_amplitude_in, Y_AMP_MAX) using 11-bit sum saturation.
REQ-025 If no slot is IDLE, the counter SHALL hold at WAIT_CYCLES and spawn on the first tick a slot frees, which is the tick after it frees.
REQ-026 In RISE, offset SHALL += Y_STEP while offset<amp; otherwise the slot goes to FALL with offset unchanged.
REQ-027 In FALL, offset<=Y_STEP SHALL set offset=0 and state GROUND; otherwise offset -= Y_STEP.
REQ-028 In GROUND, offset SHALL stay 0.
REQ-029 Every active slot SHALL apply x -= speed each tick.
REQ-030 If x<=speed before subtraction, the slot SHALL go IDLE, set x=640, and raise pass_pulse (exit); no wrap below 0.
REQ-031 An active slot with collision_vec[i]=1 on a tick SHALL go IDLE with x=640 and raise hit_pulse; collision SHALL take priority over exit, which gives no pass_pulse.
REQ-032 collision_vec bits for IDLE slots SHALL be ignored.
REQ-033 obs_y SHALL be registered as Y_BASELINE-OBS_H-offset, updated the same tick as offset; an IDLE slot reads Y_BASELINE-OBS_H.
REQ-034 pass_pulse and hit_pulse SHALL be high exactly one clk after the tick.
REQ-035 pass_pulse and hit_pulse SHALL each OR across all slots, so multiple same-tick events give one pulse.
REQ-036 The pass counter SHALL increment once per tick with any exit.

Reset
REQ-037 On rst=0, at any time including mid-flight, all slots SHALL go IDLE and all obs_x SHALL read 640.
REQ-038 On rst=0, all obs_y SHALL read Y_BASELINE-OBS_H, obs_active=0, and offsets and amps SHALL be 0.
REQ-039 On rst=0, the spawn and pass counters SHALL be 0, speed SHALL be SPEED_INIT, and pulses SHALL be 0.
REQ-040 The first spawn after reset release SHALL occur on tick WAIT_CYCLES+1.

Configuration
REQ-041 With macro OBS_SPEED_RAMP_EN defined, speed SHALL increment by 1 when the pass counter reaches PASSES_PER_STEP, and that counter SHALL then clear.
REQ-042 With OBS_SPEED_RAMP_EN defined, speed SHALL saturate at SPEED_MAX, and any hit SHALL restore speed to SPEED_INIT and clear the pass counter.
REQ-043 Without OBS_SPEED_RAMP_EN, speed SHALL be constant SPEED_INIT and the pass counter logic SHALL be absent.

Verification
REQ-044 Reset, then 13 ticks, amp_in=20 -> slot0 active on tick 13 at x=640, y=285; after 5 more ticks x=615, y=270.
REQ-045 amp_in=900 -> latched amp=200, and the peak y is never below 285-201.
REQ-046 Run continuous ticks with no collisions -> slots 0,1,2 spawn 13 ticks apart; while all are active the counter holds, and the first exit respawns slot 0 the next tick.
REQ-047 Assert collision_vec[1] on the same tick slot1 satisfies x<=speed -> slot1 IDLE, a single hit_pulse, no pass_pulse.
REQ-048 With OBS_SPEED_RAMP_EN -> 4 exits give speed=6, reaching 12 and holding; one hit -> speed=5.
REQ-049 Assert rst=0 mid-flight during FALL -> all outputs at reset values within the same clk; the next spawn follows REQ-040.
